// File: rtl/mem_port_arbiter_if.sv
// Bundle between the pipeline requesters, the arbiter and the unified memory.
// slave is the arbiter's view; master is the view of the pipeline plus memory around it.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  if_req;
   logic [31:0]           if_addr;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_ready;
   logic                  dm_req;
   logic                  dm_we;
   logic [31:0]           dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic [DATA_WIDTH-1:0] dm_rdata;
   logic                  dm_ready;
   logic                  stall_if;
   logic                  stall_dm;
   logic                  busy;
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ready, dm_rdata, dm_ready, stall_if, stall_dm, busy,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ready, dm_rdata, dm_ready, stall_if, stall_dm, busy,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data access: MEM has priority,
// a streak limit guarantees fetch progress, and every memory command is registered.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH    = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int READ_LATENCY  = 2,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e                state_q, state_d;
   logic [3:0]            streak_q, streak_d;
   logic [2:0]            lat_q, lat_d;
   logic                  win_dm_q, win_dm_d;
   logic                  we_q, we_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic                  grant_dm;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{bus.if_addr[31:ADDR_WIDTH+2], bus.if_addr[1:0],
                               bus.dm_addr[31:ADDR_WIDTH+2], bus.dm_addr[1:0]};

   // MEM wins a tie unless it has already starved IF for MAX_DM_STREAK grants
   assign grant_dm = bus.dm_req & (~bus.if_req | (streak_q != 4'(MAX_DM_STREAK)));

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      lat_d       = lat_q;
      win_dm_d    = win_dm_q;
      we_d        = we_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = '0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.if_req | bus.dm_req) begin
               state_d     = ISSUE;
               win_dm_d    = grant_dm;
               we_d        = grant_dm & bus.dm_we;
               mem_en_d    = 1'b1;
               mem_we_d    = grant_dm & bus.dm_we;
               mem_addr_d  = grant_dm ? bus.dm_addr[ADDR_WIDTH+1:2] : bus.if_addr[ADDR_WIDTH+1:2];
               mem_wdata_d = (grant_dm & bus.dm_we) ? bus.dm_wdata : '0;
               streak_d    = (grant_dm & bus.if_req) ? streak_q + 4'd1 : 4'd0;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = DONE;
            end else begin
               lat_d   = 3'(READ_LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            lat_d = lat_q - 3'd1;
            if (lat_q == 3'd1) begin
               state_d = DONE;
               if (win_dm_q) dm_rdata_d = bus.mem_rdata;
               else          if_rdata_d = bus.mem_rdata;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         lat_q       <= '0;
         win_dm_q    <= 1'b0;
         we_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         lat_q       <= lat_d;
         win_dm_q    <= win_dm_d;
         we_q        <= we_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign bus.if_ready  = (state_q == DONE) & ~win_dm_q;
   assign bus.dm_ready  = (state_q == DONE) &  win_dm_q;
   assign bus.stall_if  = bus.if_req & ~bus.if_ready;
   assign bus.stall_dm  = bus.dm_req & ~bus.dm_ready;
   assign bus.busy      = (state_q != IDLE);
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (READ_LATENCY 2, 1, 4) with exact-latency memory models;
// completions are matched against a queue of expected requester/data/cycle entries.
module tb_mem_port_arbiter;
   typedef struct {
      logic        is_dm;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b0 ();
   mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b1 ();
   mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b2 ();

   mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(2), .MAX_DM_STREAK(4))
      u0 (.clk(clk), .reset(rst), .bus(b0));
   mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1), .MAX_DM_STREAK(4))
      u1 (.clk(clk), .reset(rst), .bus(b1));
   mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(4), .MAX_DM_STREAK(4))
      u2 (.clk(clk), .reset(rst), .bus(b2));

   function automatic logic [31:0] init_word(int i);
      return 32'h2010_0000 + 32'(2 * i + 1);
   endfunction

   // memory models: read data is valid only in the single cycle READ_LATENCY after issue
   logic        m_en    [3];
   logic        m_we    [3];
   logic [9:0]  m_addr  [3];
   logic [31:0] m_wdata [3];
   logic [31:0] mem     [3][1024];
   logic [31:0] pd      [3][1:4];
   logic        pv      [3][1:4];
   logic        minit = 1'b0;

   assign m_en[0] = b0.mem_en;  assign m_we[0] = b0.mem_we;
   assign m_en[1] = b1.mem_en;  assign m_we[1] = b1.mem_we;
   assign m_en[2] = b2.mem_en;  assign m_we[2] = b2.mem_we;
   assign m_addr[0] = b0.mem_addr;  assign m_wdata[0] = b0.mem_wdata;
   assign m_addr[1] = b1.mem_addr;  assign m_wdata[1] = b1.mem_wdata;
   assign m_addr[2] = b2.mem_addr;  assign m_wdata[2] = b2.mem_wdata;
   assign b0.mem_rdata = pv[0][2] ? pd[0][2] : 32'hBAD0_BAD0;
   assign b1.mem_rdata = pv[1][1] ? pd[1][1] : 32'hBAD0_BAD0;
   assign b2.mem_rdata = pv[2][4] ? pd[2][4] : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      if (!minit) begin
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1024; i++) mem[k][i] <= init_word(i);
            for (int s = 1; s <= 4; s++) begin
               pd[k][s] <= '0;
               pv[k][s] <= 1'b0;
            end
         end
         minit <= 1'b1;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (m_en[k] && m_we[k]) mem[k][m_addr[k]] <= m_wdata[k];
            pd[k][1] <= mem[k][m_addr[k]];
            pv[k][1] <= m_en[k] && !m_we[k];
            for (int s = 2; s <= 4; s++) begin
               pd[k][s] <= pd[k][s-1];
               pv[k][s] <= pv[k][s-1];
            end
         end
      end
   end

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc_n = 0;
   exp_t        sb[$];
   logic        hold_if = 1'b0;
   logic        hold_dm = 1'b0;
   logic [31:0] last_dm_rd = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   task automatic push(input logic is_dm, input logic [31:0] data, input int cyc);
      exp_t e;
      e.is_dm = is_dm;
      e.data  = data;
      e.cyc   = cyc;
      sb.push_back(e);
   endtask

   // one cycle on b0: match any completion against the queue, then the requester drops req
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      cyc_n++;
      if (b0.if_ready || b0.dm_ready) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ready_who", {30'd0, b0.if_ready, b0.dm_ready}, {30'd0, ~e.is_dm, e.is_dm});
            chk("rdata", e.is_dm ? b0.dm_rdata : b0.if_rdata, e.data);
            if (e.cyc >= 0) chk("ready_cycle", 32'(cyc_n), 32'(e.cyc));
         end
         if (b0.if_ready && !hold_if) b0.if_req = 1'b0;
         if (b0.dm_ready && !hold_dm) b0.dm_req = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, n_rdy, en1, en2;
      b0.if_req = 0; b0.if_addr = '0; b0.dm_req = 0; b0.dm_we = 0; b0.dm_addr = '0; b0.dm_wdata = '0;
      b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
      b2.if_req = 0; b2.if_addr = '0; b2.dm_req = 0; b2.dm_we = 0; b2.dm_addr = '0; b2.dm_wdata = '0;

      // reset state
      repeat (3) cyc();
      chk("rst_busy", 32'(b0.busy), 0);
      chk("rst_mem_en", 32'(b0.mem_en), 0);
      chk("rst_mem_addr", 32'(b0.mem_addr), 0);
      chk("rst_ready", {30'd0, b0.if_ready, b0.dm_ready}, 0);
      chk("rst_if_rdata", b0.if_rdata, 0);
      chk("rst_dm_rdata", b0.dm_rdata, 0);
      rst = 1'b0;
      cyc();

      // single IF read
      t0 = cyc_n;
      b0.if_req = 1; b0.if_addr = 32'h0000_0008;
      push(1'b0, 32'h2010_0005, t0 + 4);
      #1 chk("if_stall_c0", 32'(b0.stall_if), 1);
      for (int k = 1; k <= 6; k++) begin
         cyc();
         if (k == 1) begin
            chk("if_mem_en", 32'(b0.mem_en), 1);
            chk("if_mem_addr", 32'(b0.mem_addr), 2);
            chk("if_mem_we", 32'(b0.mem_we), 0);
         end
         if (k == 2) chk("if_wait_en", 32'(b0.mem_en), 0);
         if (k <= 3) chk("if_stall", 32'(b0.stall_if), 1);
         if (k == 4) chk("if_stall_rdy", 32'(b0.stall_if), 0);
         if (k == 5) chk("if_idle", 32'(b0.busy), 0);
      end

      // MEM write
      t0 = cyc_n;
      b0.dm_req = 1; b0.dm_we = 1; b0.dm_addr = 32'h0000_0010; b0.dm_wdata = 32'hDEAD_BEEF;
      push(1'b1, last_dm_rd, t0 + 2);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         if (k == 1) begin
            chk("wr_mem_en", 32'(b0.mem_en), 1);
            chk("wr_mem_we", 32'(b0.mem_we), 1);
            chk("wr_mem_addr", 32'(b0.mem_addr), 4);
            chk("wr_mem_wdata", b0.mem_wdata, 32'hDEAD_BEEF);
         end
         if (k == 3) begin
            chk("wr_after_we", 32'(b0.mem_we), 0);
            chk("wr_after_wdata", b0.mem_wdata, 0);
            chk("wr_addr_hold", 32'(b0.mem_addr), 4);
         end
      end

      // simultaneous: MEM read of the word just written, then IF (addr low bits ignored)
      t0 = cyc_n;
      b0.dm_req = 1; b0.dm_we = 0; b0.dm_addr = 32'h0000_0010;
      b0.if_req = 1; b0.if_addr = 32'h0000_0023;
      push(1'b1, 32'hDEAD_BEEF, t0 + 4);
      push(1'b0, init_word(8), t0 + 9);
      last_dm_rd = 32'hDEAD_BEEF;
      for (int k = 1; k <= 11; k++) begin
         cyc();
         if (k == 1) chk("sim_first_addr", 32'(b0.mem_addr), 4);
         if (k == 6) chk("sim_second_addr", 32'(b0.mem_addr), 8);
         if (k == 6) chk("sim_second_en", 32'(b0.mem_en), 1);
      end

      // starvation guard: both held, MEM writes vs IF reads
      hold_if = 1; hold_dm = 1;
      b0.dm_req = 1; b0.dm_we = 1; b0.dm_addr = 32'h0000_0040; b0.dm_wdata = 32'h1234_5678;
      b0.if_req = 1; b0.if_addr = 32'h0000_000C;
      for (int r = 0; r < 2; r++) begin
         for (int m = 0; m < 4; m++) push(1'b1, last_dm_rd, -1);
         push(1'b0, init_word(3), -1);
      end
      n_rdy = 0;
      for (int k = 0; k < 120 && n_rdy < 10; k++) begin
         cyc();
         if (b0.if_ready || b0.dm_ready) n_rdy++;
         if (n_rdy == 10) begin
            b0.if_req = 0; b0.dm_req = 0; hold_if = 0; hold_dm = 0;
         end
      end
      chk("starve_grants", 32'(n_rdy), 10);
      repeat (2) cyc();
      chk("starve_idle", 32'(b0.busy), 0);

      // reset during WAIT, then a fresh full-latency read
      b0.if_req = 1; b0.if_addr = 32'h0000_0014;
      repeat (3) cyc();
      chk("mid_busy", 32'(b0.busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(b0.busy), 0);
      chk("mid_rst_en", 32'(b0.mem_en), 0);
      chk("mid_rst_addr", 32'(b0.mem_addr), 0);
      chk("mid_rst_ready", {30'd0, b0.if_ready, b0.dm_ready}, 0);
      chk("mid_rst_if_rdata", b0.if_rdata, 0);
      chk("mid_rst_dm_rdata", b0.dm_rdata, 0);
      last_dm_rd = '0;
      cyc();
      rst = 1'b0;
      t0 = cyc_n;
      push(1'b0, init_word(5), t0 + 4);
      for (int k = 1; k <= 6; k++) begin
         cyc();
         if (k == 1) chk("post_rst_en", 32'(b0.mem_en), 1);
         if (k == 1) chk("post_rst_addr", 32'(b0.mem_addr), 5);
      end

      // latency sweep: READ_LATENCY 1 and 4
      b1.if_req = 1; b1.if_addr = 32'h0000_0008;
      b2.if_req = 1; b2.if_addr = 32'h0000_0018;
      en1 = 0; en2 = 0;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         if (b1.mem_en) en1++;
         if (b2.mem_en) en2++;
         chk("rl1_ready", 32'(b1.if_ready), 32'(k == 3));
         chk("rl4_ready", 32'(b2.if_ready), 32'(k == 6));
         if (b1.if_ready) begin
            chk("rl1_rdata", b1.if_rdata, 32'h2010_0005);
            b1.if_req = 0;
         end
         if (b2.if_ready) begin
            chk("rl4_rdata", b2.if_rdata, init_word(6));
            b2.if_req = 0;
         end
      end
      chk("rl1_issue_count", 32'(en1), 1);
      chk("rl4_issue_count", 32'(en2), 1);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (MEM). It grants one access at a time and issues a registered command to the memory. It returns read data through a per-requester ready pulse and drives stall signals so the pipeline registers hold while an access is pending. Data accesses take priority; a streak limit guarantees fetch forward progress.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width of memory (1024 words)
- DATA_WIDTH, 32, data width
- READ_LATENCY, 2, cycles from issue cycle to valid mem_rdata (legal 1..4)
- MAX_DM_STREAK, 4, max consecutive MEM grants while IF is waiting (legal 1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch read request; held until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  DATA_WIDTH  fetched word, valid while if_ready
- if_ready  out  1  one-cycle completion pulse for IF
- dm_req  in  1  MEM-stage request; held until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  32  data byte address
- dm_wdata  in  DATA_WIDTH  write data
- dm_rdata  out  DATA_WIDTH  read word, valid while dm_ready
- dm_ready  out  1  one-cycle completion pulse for MEM
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_dm  out  1  dm_req & ~dm_ready (combinational)
- busy  out  1  high in any state other than IDLE
- mem_en  out  1  memory command strobe (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_WIDTH  word address = byte_addr[ADDR_WIDTH+1:2] (registered)
- mem_wdata  out  DATA_WIDTH  write data (registered)
- mem_rdata  in  DATA_WIDTH  read data from memory

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any request is present, arbitrate and latch the winner, we, addr and wdata, then go to ISSUE.
  - IF requests are always reads; if_addr bits [1:0] are ignored.
- **Arbitration**
  - dm_req alone: MEM wins. if_req alone: IF wins.
  - Both requesting: MEM wins unless streak == MAX_DM_STREAK, in which case IF wins.
- **Streak counter** (4 bits), updated at each grant:
  - MEM granted while if_req = 1: increment.
  - IF granted, or MEM granted while if_req = 0: clear to 0.
- **ISSUE** (exactly one cycle)
  - mem_en = 1 with the latched command.
  - Write: go to DONE.
  - Read: load the latency counter with READ_LATENCY and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into the winner's rdata register and go to DONE.
- **DONE** (exactly one cycle)
  - Pulse the winner's ready.
  - Requests are ignored in this cycle, so a request still held does not re-issue.
  - Go to IDLE.
- **Requester behaviour**
  - A requester that drops req mid-transaction is not aborted; its ready still pulses.
  - Address and data changes after the grant are ignored.
- **Output registers**
  - if_rdata and dm_rdata hold their last captured value between transactions.
  - A write transaction does not modify dm_rdata.
- mem_en, mem_we and mem_wdata are 0 in every state except ISSUE. mem_addr holds its last value.
- **Reset**, asynchronous and allowed mid-transaction:
  - State goes to IDLE; streak and latency counter go to 0.
  - Cleared to 0: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready, busy.
  - The in-flight transaction is discarded with no ready pulse.

## Timing
- Request sampled at the rising edge ending cycle N (IDLE). ISSUE is cycle N+1.
- **Read:** mem_rdata valid in cycle N+1+READ_LATENCY and captured at that cycle's closing edge. Ready pulses in cycle N+2+READ_LATENCY.
- **Write:** the memory samples the command at the edge ending N+1. dm_ready pulses in cycle N+2.
- Back-to-back throughput:
  - A new request can be sampled in the IDLE cycle after DONE.
  - Read period = READ_LATENCY+3 cycles; write period = 3 cycles.
- The stall_* signals are combinational from req and ready and are low in the ready cycle, so the pipeline advances on that cycle's edge.
- No path from *_req or *_addr to mem_* outputs is combinational.

## Test plan
- **Single IF read**, READ_LATENCY = 2: if_req = 1, if_addr = 0x0000_0008 sampled at cycle 0.
  - mem_en = 1, mem_addr = 2 in cycle 1.
  - Memory model returns 0x2010_0005 in cycle 3.
  - if_ready = 1 and if_rdata = 0x2010_0005 in cycle 4 only; stall_if = 1 in cycles 0–3.
- **MEM write**: dm_req = 1, dm_we = 1, dm_addr = 0x0000_0010, dm_wdata = 0xDEAD_BEEF at cycle 0.
  - Cycle 1: mem_en = 1, mem_we = 1, mem_addr = 4, mem_wdata = 0xDEAD_BEEF.
  - Cycle 2: dm_ready pulse; dm_rdata unchanged.
- **Simultaneous requests**: if_req and dm_req both asserted at cycle 0 with streak 0. MEM is granted first. IF is sampled in cycle 1+READ_LATENCY+2 (cycle 5 for READ_LATENCY = 2) and completes in cycle 9.
- **Starvation guard**, MAX_DM_STREAK = 4: dm_req held continuously (re-requesting each IDLE) and if_req held. Grant order is MEM ×4, IF, MEM ×4, IF.
- **Reset mid-read**: assert reset during WAIT.
  - Immediately: state IDLE, mem_en = 0, if_ready/dm_ready = 0, rdata outputs 0.
  - After release with if_req still high, a fresh transaction starts with full latency.
- **Latency sweep**: READ_LATENCY = 1 and 4. Ready lands in cycle N+3 and N+6 respectively. A request held through DONE does not issue a second memory access in the DONE cycle.
